ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter for the Nexys A7 keyboard path. It sends one command byte to the keyboard, such as 0xED set-LEDs, 0xFF reset or 0xF4 enable, using the PS/2 host request-to-send sequence, then reports the device ACK. It sits beside the PS/2 keyboard receiver on the same PS2_CLK/PS2_DATA pins and drives them open-drain through the top level. While it is busy, the receiver must ignore the lines.

## Interface
Parameters:
- CLK_FREQ_HZ, 100_000_000: system clock frequency.
- INHIBIT_CYCLES, 10_000: clock-low inhibit time (100 us).
- FILTER_LEN, 16: cycles a synchronized PS/2 input must be stable before the filtered value changes.
- TIMEOUT_CYCLES, 2_000_000: watchdog limit (20 ms).

Ports:
- CLK100MHZ, in, 1: the block's single clock.
- CPU_RESETN, in, 1: reset, asynchronous, active-low.
- tx_valid, in, 1: a byte is offered for transmission.
- tx_data, in, 8: the command byte.
- tx_ready, out, 1: block is idle and accepts a byte.
- ps2_clk_in, in, 1: raw PS2_CLK pin value.
- ps2_data_in, in, 1: raw PS2_DATA pin value.
- ps2_clk_oe, out, 1: 1 = drive PS2_CLK low; 0 = release the line.
- ps2_data_oe, out, 1: 1 = drive PS2_DATA low; 0 = release the line.
- busy, out, 1: transfer in progress; the receiver gates frame capture with it.
- done, out, 1: one-cycle pulse when a transfer ends, whether it succeeded or failed.
- ack_ok, out, 1: valid while done is high; 1 = device drove ACK low.
- err, out, 1: one-cycle pulse on a missing ACK or a watchdog expiry.

## Operation
- Input conditioning: both inputs pass through a 2-FF synchronizer, then a stability filter. A filtered falling edge of PS2_CLK is "fall".
- Byte accept: the byte is accepted when tx_valid && tx_ready. The block latches tx_data and computes odd parity: par = ~^tx_data.
- IDLE:
  - tx_ready=1, both oe=0.
  - On accept, go to INHIBIT.
- INHIBIT:
  - clk_oe=1.
  - Count INHIBIT_CYCLES. At terminal count, set data_oe=1 (start bit) and go to RTS.
- RTS: one cycle with clk_oe=1 and data_oe=1, then clk_oe=0 and go to SEND with bit index 0.
- SEND: on each fall, present the next bit:
  - index 0-7: data_oe = ~tx_data[index].
  - index 8: data_oe = ~par.
  - index 9: data_oe=0 (stop bit).
  - After index 9, go to ACK.
- ACK: on the next fall, sample the filtered data line and go to WAITIDLE.
  - data low: ack_ok=1.
  - data high: ack_ok=0 and err pulses.
- WAITIDLE: wait until filtered clk=1 and data=1, then pulse done and go to IDLE.
- Busy input: tx_valid while busy is ignored. The byte is held by the sender until tx_ready returns.
- Reset:
  - Asserting CPU_RESETN mid-transfer forces IDLE asynchronously.
  - Lines are released immediately.
  - No done or err pulse is generated.
- Output reset values: tx_ready=1; ps2_clk_oe=0; ps2_data_oe=0; busy=0; done=0; ack_ok=0; err=0.

## Timing
- Accept to clk_oe=1: 1 cycle.
- clk_oe stays high for exactly INHIBIT_CYCLES+1 cycles, including the RTS cycle.
- Bit change latency: data_oe changes 1 cycle after the filtered fall, which is 2+FILTER_LEN cycles after the pin edge. This is well inside the ~40 us low phase at 10-16.7 kHz.
- done: asserted 1 cycle after idle lines are observed. busy falls in the same cycle.
- busy = ~tx_ready.
- Back-to-back transfers: the earliest next accept is the cycle after done.

## Configuration
- PS2_HOST_TX_TIMEOUT_EN defined: watchdog enabled.
  - The counter restarts on accept and on every fall.
  - If it reaches TIMEOUT_CYCLES in RTS, SEND, ACK or WAITIDLE, both oe go to 0, err and done pulse (ack_ok=0), and the state returns to IDLE.
- Undefined: no watchdog. A silent device leaves the block in SEND until reset.

## Structure
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, RTS, SEND, ACK, WAITIDLE);
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF;
  - PS2_ACK_BYTE=8'hFA, shared with the receiver.
- Sub-module ps2_sync_filter: 2-FF synchronizer plus FILTER_LEN stability counter, with a fall-edge pulse output. It is instantiated twice and is reusable by the receiver.

## Test plan
- Reset behaviour: CPU_RESETN low -> all outputs at their reset values; tx_ready=1, both oe=0.
- Normal transfer of 0xED: device BFM at 12.5 kHz, driving ACK.
  - clk_oe high for 10001 cycles.
  - BFM samples on rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Then done with ack_ok=1.
- Missing ACK: 0xF4 sent, parity observed 0; BFM leaves data high on the 11th fall -> done with ack_ok=0, err pulse.
- Watchdog, macro defined: BFM never clocks -> TIMEOUT_CYCLES after RTS, err and done pulse, both oe=0, tx_ready=1.
- Busy and reset: tx_valid held during a transfer -> second byte accepted only after done. CPU_RESETN pulsed during SEND bit 4 -> oe=0 within the same cycle, IDLE, no done.
- Glitch rejection: a 5-cycle low glitch on ps2_clk_in in SEND -> bit index unchanged, data_oe unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and keyboard receiver.
//   ps2_state_t     - transmitter FSM states
//   PS2_CMD_*       - host command bytes
//   PS2_ACK_BYTE    - device acknowledge byte, checked by the receiver
//   odd_parity_bit  - parity bit that makes data plus parity an odd count of ones
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAITIDLE
    } ps2_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    function automatic logic odd_parity_bit(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: conditions one raw PS/2 pin.
// A 2-FF synchronizer feeds a stability counter; the filtered output only
// follows the synchronized value after it has held for FILTER_LEN cycles.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (filtered output resets to idle-high)
//   din   - raw pin value
//   dout  - filtered line level
//   fall  - one-cycle pulse in the cycle dout goes from 1 to 0
`timescale 1ns/1ps
module ps2_sync_filter #(
    parameter int FILTER_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            dout       <= 1'b1;
            fall       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
            fall   <= 1'b0;
            // Any return to the current filtered level restarts the count,
            // so short glitches never reach dout.
            if (sync_b == dout) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
                dout       <= sync_b;
                fall       <= ~sync_b;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Pulls PS2_CLK low for INHIBIT_CYCLES, requests to send with a start bit,
// shifts out 8 data bits (LSB first), odd parity and stop on device clock
// falls, then samples the device ACK and waits for idle lines.
// Ports:
//   CLK100MHZ, CPU_RESETN     - clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_ready - command byte handshake
//   ps2_clk_in/ps2_data_in    - raw pin levels
//   ps2_clk_oe/ps2_data_oe    - 1 pulls the pin low (open drain)
//   busy                      - transfer in progress, gates the receiver
//   done, ack_ok, err         - end-of-transfer pulse, ACK status, error pulse
// Build option: define PS2_HOST_TX_TIMEOUT_EN to enable the TIMEOUT_CYCLES
// watchdog that aborts a transfer when the device stops clocking.
`timescale 1ns/1ps
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int FILTER_LEN     = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    // All timing is expressed in cycles; the frequency is informational.
    localparam int unused_clk_freq = CLK_FREQ_HZ;
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    logic clk_f, clk_fall;
    logic data_f, unused_data_fall;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk  (CLK100MHZ),
        .rst_n(CPU_RESETN),
        .din  (ps2_clk_in),
        .dout (clk_f),
        .fall (clk_fall)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk  (CLK100MHZ),
        .rst_n(CPU_RESETN),
        .din  (ps2_data_in),
        .dout (data_f),
        .fall (unused_data_fall)
    );

    ps2_state_t    state, state_nxt;
    logic [IW-1:0] inh_cnt, inh_cnt_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          par_q, par_nxt;
    logic          clk_oe_q, clk_oe_nxt;
    logic          data_oe_q, data_oe_nxt;
    logic          done_q, done_nxt;
    logic          ack_q, ack_nxt;
    logic          err_q, err_nxt;
    logic          wd_expired;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;

    // Restarted by every device clock fall, so it measures silence on the
    // bus rather than total transfer time.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            wd_cnt <= '0;
        end else if ((state == IDLE && tx_valid) || clk_fall) begin
            wd_cnt <= '0;
        end else if (wd_cnt != TW'(TIMEOUT_CYCLES - 1)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                        (state inside {RTS, SEND, ACK, WAITIDLE});
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= IDLE;
            inh_cnt   <= '0;
            bit_idx   <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            inh_cnt   <= inh_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            data_q    <= data_nxt;
            par_q     <= par_nxt;
            clk_oe_q  <= clk_oe_nxt;
            data_oe_q <= data_oe_nxt;
            done_q    <= done_nxt;
            ack_q     <= ack_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        inh_cnt_nxt = inh_cnt;
        bit_idx_nxt = bit_idx;
        data_nxt    = data_q;
        par_nxt     = par_q;
        clk_oe_nxt  = clk_oe_q;
        data_oe_nxt = data_oe_q;
        ack_nxt     = ack_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    data_nxt    = tx_data;
                    par_nxt     = odd_parity_bit(tx_data);
                    ack_nxt     = 1'b0;
                    inh_cnt_nxt = '0;
                    clk_oe_nxt  = 1'b1;
                    state_nxt   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_nxt = 1'b1;
                    state_nxt   = RTS;
                end else begin
                    inh_cnt_nxt = inh_cnt + 1'b1;
                end
            end
            RTS: begin
                clk_oe_nxt  = 1'b0;
                bit_idx_nxt = '0;
                state_nxt   = SEND;
            end
            SEND: begin
                // Data changes while the device holds the clock low; the
                // device samples it on the following rising edge.
                if (clk_fall) begin
                    if (bit_idx < 4'd8) begin
                        data_oe_nxt = ~data_q[bit_idx[2:0]];
                    end else if (bit_idx == 4'd8) begin
                        data_oe_nxt = ~par_q;
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ACK;
                    end
                    bit_idx_nxt = bit_idx + 4'd1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_nxt   = ~data_f;
                    err_nxt   = data_f;
                    state_nxt = WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (clk_f && data_f) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (wd_expired) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            ack_nxt     = 1'b0;
            err_nxt     = 1'b1;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_ok      = done_q & ack_q;
    assign err         = err_q;

endmodule
